// File: rtl/core_bus_xbar.sv
// ---------------------------------------------------------------------------
// core_bus_xbar
//
// Core-side crossbar. Connects NB_MASTER core request ports (req/gnt/rvalid)
// to NB_SLAVE single-port SRAM-style slaves with one-cycle read latency.
// Each slave, plus an internal error slave for unmapped addresses, has its
// own round-robin arbiter. Grants are combinational. Responses arrive one
// cycle after the grant.
//
// Optional feature macro: CORE_BUS_ERR_EN
//   When defined, adds m_err_o (pulses with rvalid for accesses decoded to
//   the error slave) and err_addr_o (first unmapped address after reset).
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_addr_i, end_addr_i  per-slave inclusive byte-address regions
//   m_req_i / m_gnt_o         master request / combinational grant
//   m_rvalid_o, m_rdata_o     master response, one cycle after grant
//   m_addr_i, m_we_i, m_be_i, m_wdata_i   master request payload
//   s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o   slave request (word addr)
//   s_rdata_i                 slave read data, valid the cycle after s_req_o
//   m_err_o, err_addr_o       only with CORE_BUS_ERR_EN
// ---------------------------------------------------------------------------
module core_bus_xbar #(
    parameter int NB_MASTER      = 2,
    parameter int NB_SLAVE       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLV_ADDR_WIDTH = 15,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADC_0FFE
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NB_SLAVE*ADDR_WIDTH-1:0]        start_addr_i,
    input  logic [NB_SLAVE*ADDR_WIDTH-1:0]        end_addr_i,
    input  logic [NB_MASTER-1:0]                  m_req_i,
    output logic [NB_MASTER-1:0]                  m_gnt_o,
    output logic [NB_MASTER-1:0]                  m_rvalid_o,
    input  logic [NB_MASTER*ADDR_WIDTH-1:0]       m_addr_i,
    input  logic [NB_MASTER-1:0]                  m_we_i,
    input  logic [NB_MASTER*DATA_WIDTH/8-1:0]     m_be_i,
    input  logic [NB_MASTER*DATA_WIDTH-1:0]       m_wdata_i,
    output logic [NB_MASTER*DATA_WIDTH-1:0]       m_rdata_o,
`ifdef CORE_BUS_ERR_EN
    output logic [NB_MASTER-1:0]                  m_err_o,
    output logic [ADDR_WIDTH-1:0]                 err_addr_o,
`endif
    output logic [NB_SLAVE-1:0]                   s_req_o,
    output logic [NB_SLAVE*SLV_ADDR_WIDTH-1:0]    s_addr_o,
    output logic [NB_SLAVE-1:0]                   s_we_o,
    output logic [NB_SLAVE*DATA_WIDTH/8-1:0]      s_be_o,
    output logic [NB_SLAVE*DATA_WIDTH-1:0]        s_wdata_o,
    input  logic [NB_SLAVE*DATA_WIDTH-1:0]        s_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int OFFSET   = $clog2(BE_WIDTH);
    localparam int MST_W    = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int NB_TGT   = NB_SLAVE + 1;
    localparam int TGT_W    = $clog2(NB_TGT);
    // The error slave sits one index past the last real slave.
    localparam int ERR_IDX  = NB_SLAVE;

    logic [ADDR_WIDTH-1:0] m_addr     [NB_MASTER];
    logic [BE_WIDTH-1:0]   m_be       [NB_MASTER];
    logic [DATA_WIDTH-1:0] m_wdata    [NB_MASTER];
    logic [ADDR_WIDTH-1:0] start_addr [NB_SLAVE];
    logic [ADDR_WIDTH-1:0] end_addr   [NB_SLAVE];
    logic [TGT_W-1:0]      tgt        [NB_MASTER];
    logic [NB_MASTER-1:0]  req_act;

    logic [NB_TGT-1:0]     gnt_vld;
    logic [MST_W-1:0]      win        [NB_TGT];
    logic [MST_W-1:0]      ptr_q      [NB_TGT];
    logic [NB_TGT-1:0]     resp_vld_q;
    logic [MST_W-1:0]      resp_own_q [NB_TGT];
    logic [DATA_WIDTH-1:0] rdata      [NB_MASTER];

    // Requests are masked while reset is held, so no grant or slave strobe
    // can leak out during reset.
    assign req_act = m_req_i & {NB_MASTER{rst_ni}};

    // Split the flat port buses into per-master and per-slave fields.
    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            m_addr[m]  = m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
            m_be[m]    = m_be_i[m*BE_WIDTH +: BE_WIDTH];
            m_wdata[m] = m_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int s = 0; s < NB_SLAVE; s++) begin
            start_addr[s] = start_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH];
            end_addr[s]   = end_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Address decode: scanning from the highest index down lets the lowest
    // matching region win when regions overlap.
    always_comb begin
        for (int m = 0; m < NB_MASTER; m++) begin
            tgt[m] = TGT_W'(ERR_IDX);
            for (int s = NB_SLAVE - 1; s >= 0; s--) begin
                if (m_addr[m] >= start_addr[s] && m_addr[m] <= end_addr[s]) begin
                    tgt[m] = TGT_W'(s);
                end
            end
        end
    end

    // Per-target round-robin: the first requester found when walking
    // forward from ptr_q wins.
    always_comb begin
        logic [MST_W:0]   sum;
        logic [MST_W-1:0] idx;
        sum = '0;
        idx = '0;
        for (int t = 0; t < NB_TGT; t++) begin
            gnt_vld[t] = 1'b0;
            win[t]     = '0;
            for (int k = 0; k < NB_MASTER; k++) begin
                sum = {1'b0, ptr_q[t]} + (MST_W+1)'(k);
                if (sum >= (MST_W+1)'(NB_MASTER)) begin
                    sum = sum - (MST_W+1)'(NB_MASTER);
                end
                idx = sum[MST_W-1:0];
                if (!gnt_vld[t] && req_act[idx] && tgt[idx] == TGT_W'(t)) begin
                    gnt_vld[t] = 1'b1;
                    win[t]     = idx;
                end
            end
        end
    end

    // A master targets exactly one slave, so at most one arbiter grants it.
    always_comb begin
        m_gnt_o = '0;
        for (int t = 0; t < NB_TGT; t++) begin
            if (gnt_vld[t]) begin
                m_gnt_o[win[t]] = 1'b1;
            end
        end
    end

    // Forward the winning request to its slave; idle slaves see all zeros.
    always_comb begin
        s_req_o   = '0;
        s_addr_o  = '0;
        s_we_o    = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (gnt_vld[s]) begin
                s_req_o[s] = 1'b1;
                s_addr_o[s*SLV_ADDR_WIDTH +: SLV_ADDR_WIDTH] =
                    SLV_ADDR_WIDTH'((m_addr[win[s]] - start_addr[s]) >> OFFSET);
                s_we_o[s] = m_we_i[win[s]];
                s_be_o[s*BE_WIDTH +: BE_WIDTH] = m_be[win[s]];
                s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata[win[s]];
            end
        end
    end

    // Remember who owns each target's response for the next cycle and move
    // the round-robin pointer past the winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_vld_q <= '0;
            for (int t = 0; t < NB_TGT; t++) begin
                resp_own_q[t] <= '0;
                ptr_q[t]      <= '0;
            end
        end else begin
            resp_vld_q <= gnt_vld;
            for (int t = 0; t < NB_TGT; t++) begin
                if (gnt_vld[t]) begin
                    resp_own_q[t] <= win[t];
                    ptr_q[t]      <= (win[t] == MST_W'(NB_MASTER - 1)) ? '0 : win[t] + MST_W'(1);
                end
            end
        end
    end

    // Route each pending response to its owner. Error-slave responses always
    // carry ERR_RDATA; writes to it are simply never forwarded anywhere.
    always_comb begin
        m_rvalid_o = '0;
`ifdef CORE_BUS_ERR_EN
        m_err_o = '0;
`endif
        for (int m = 0; m < NB_MASTER; m++) begin
            rdata[m] = '0;
        end
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (resp_vld_q[s]) begin
                m_rvalid_o[resp_own_q[s]] = 1'b1;
                rdata[resp_own_q[s]]      = s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (resp_vld_q[ERR_IDX]) begin
            m_rvalid_o[resp_own_q[ERR_IDX]] = 1'b1;
            rdata[resp_own_q[ERR_IDX]]      = ERR_RDATA;
`ifdef CORE_BUS_ERR_EN
            m_err_o[resp_own_q[ERR_IDX]]    = 1'b1;
`endif
        end
    end

    // Flatten per-master read data back onto the port bus.
    always_comb begin
        m_rdata_o = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            m_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = rdata[m];
        end
    end

`ifdef CORE_BUS_ERR_EN
    logic                  err_seen_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    // Only the first unmapped address after reset is kept, so a later burst
    // of bad accesses cannot hide the original fault.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_seen_q <= 1'b0;
            err_addr_q <= '0;
        end else if (gnt_vld[ERR_IDX] && !err_seen_q) begin
            err_seen_q <= 1'b1;
            err_addr_q <= m_addr[win[ERR_IDX]];
        end
    end

    assign err_addr_o = err_addr_q;
`endif

endmodule
